// File: rtl/hdmi_tmds_framer.sv
// hdmi_tmds_framer: RGB888 + sync/de to three TMDS symbol lanes in the pixel
// clock domain. A look-ahead delay line of PREAMBLE_LEN+GUARD_LEN stages lets
// the output FSM emit an HDMI video preamble and leading guard band ahead of
// the first pixel of each line. Build option: define HDMI_GUARD_BAND_EN to
// enable preamble/guard insertion; leave it undefined for plain DVI output
// with identical latency.
//
// state    | meaning
// ST_CTRL  | blanking, control symbols on all lanes
// ST_PRE   | video preamble (lane1 CTL 01, lane2 CTL 00)
// ST_GUARD | leading video guard band
// ST_VIDEO | TMDS-encoded pixels
module hdmi_tmds_framer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [23:0] video_din,
  input  logic        video_hsync,
  input  logic        video_vsync,
  input  logic        video_de,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic        de_out,
  output logic        blank_short
);

  localparam int D = PREAMBLE_LEN + GUARD_LEN;

  localparam logic [1:0] ST_CTRL  = 2'd0;
  localparam logic [1:0] ST_VIDEO = 2'd3;

  localparam logic [9:0] SYM_CTL00  = 10'b1101010100;
  localparam logic [9:0] SYM_CTL01  = 10'b0010101011;
  localparam logic [9:0] SYM_CTL10  = 10'b0101010100;
  localparam logic [9:0] SYM_CTL11  = 10'b1010101011;
  localparam logic [9:0] SYM_GUARD_BR = 10'b1011001100;
  localparam logic [9:0] SYM_GUARD_G  = 10'b0100110011;

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = SYM_CTL00;
      2'b01:   s = SYM_CTL01;
      2'b10:   s = SYM_CTL10;
      default: s = SYM_CTL11;
    endcase
    return s;
  endfunction

  // Transition minimisation: 9-bit q_m, bit 8 set when the XOR chain is used.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, d[i]};
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC balance: returns {next disparity, symbol}; disparity is 5-bit two's complement.
  function automatic logic [14:0] tmds_dc(input logic [8:0] qm, input logic [4:0] disp);
    logic [3:0] ones;
    logic [4:0] diff;
    logic [4:0] nd;
    logic [9:0] sym;
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, qm[i]};
    diff = {ones, 1'b0} - 5'd8;
    if ((disp == 5'd0) || (diff == 5'd0)) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nd  = qm[8] ? (disp + diff) : (disp - diff);
    end else if (disp[4] == diff[4]) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nd  = disp + {3'b000, qm[8], 1'b0} - diff;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nd  = disp - {3'b000, ~qm[8], 1'b0} + diff;
    end
    return {nd, sym};
  endfunction

  // {de, vsync, hsync, rgb}
  logic [26:0]        in_r;
  logic [D-1:0][26:0] dly;
  logic [26:0]        src;
  logic [8:0]         s1_qm0, s1_qm1, s1_qm2;
  logic [1:0]         s1_c;
  logic               s1_de;
  logic [1:0]         state;
  logic               is_pre, is_guard;
  logic [4:0]         disp0, disp1, disp2;
  logic [14:0]        enc0, enc1, enc2;

  assign src = dly[D-1];

  // Input capture (also the one-cycle de history) and look-ahead delay line.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      in_r <= '0;
      dly  <= '0;
    end else begin
      in_r <= {video_de, video_vsync, video_hsync, video_din};
      dly  <= {dly[D-2:0], in_r};
    end
  end

  // Encode stage: transition minimisation and control bits, aligned with the FSM.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_qm0 <= '0;
      s1_qm1 <= '0;
      s1_qm2 <= '0;
      s1_c   <= '0;
      s1_de  <= 1'b0;
    end else begin
      s1_qm0 <= tmds_qm(src[7:0]);
      s1_qm1 <= tmds_qm(src[15:8]);
      s1_qm2 <= tmds_qm(src[23:16]);
      s1_c   <= src[25:24];
      s1_de  <= src[26];
    end
  end

`ifdef HDMI_GUARD_BAND_EN
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [3:0] PRE_LOAD   = 4'(PREAMBLE_LEN);
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_LEN);

  logic [D-1:0] tap_de;
  logic         rise, room;
  logic [3:0]   cnt;

  // Gather the de bit of every delay tap for the blanking-length test.
  always_comb begin
    tap_de = '0;
    for (int i = 0; i < D; i++) tap_de[i] = dly[i][26];
  end

  // Line is framed only when the whole look-ahead window is blank and idle.
  assign rise = in_r[26] & ~dly[0][26];
  assign room = (tap_de == '0) && (state == ST_CTRL);

  // Output-stage FSM with terminal-count down-counter for preamble and guard.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CTRL;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CTRL: begin
          if (rise && room) begin
            state <= ST_PRE;
            cnt   <= PRE_LOAD;
          end else if (src[26]) begin
            state <= ST_VIDEO;
          end
        end
        ST_PRE: begin
          if (cnt == 4'd1) begin
            state <= ST_GUARD;
            cnt   <= GUARD_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GUARD: begin
          if (cnt == 4'd1) state <= ST_VIDEO;
          else             cnt   <= cnt - 4'd1;
        end
        ST_VIDEO: if (!src[26]) state <= ST_CTRL;
        default: state <= ST_CTRL;
      endcase
    end
  end

  // Flag a line that starts without room for preamble and guard.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) blank_short <= 1'b0;
    else          blank_short <= rise & ~room;
  end

  assign is_pre   = (state == ST_PRE);
  assign is_guard = (state == ST_GUARD);
`else
  // DVI-only FSM: follows the delayed de between blanking and video.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= ST_CTRL;
    else          state <= src[26] ? ST_VIDEO : ST_CTRL;
  end

  assign blank_short = 1'b0;
  assign is_pre      = 1'b0;
  assign is_guard    = 1'b0;
`endif

  assign enc0 = tmds_dc(s1_qm0, disp0);
  assign enc1 = tmds_dc(s1_qm1, disp1);
  assign enc2 = tmds_dc(s1_qm2, disp2);

  // Output register: symbol select per state, disparity cleared outside video.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      tmds_ch0 <= SYM_CTL00;
      tmds_ch1 <= SYM_CTL00;
      tmds_ch2 <= SYM_CTL00;
      de_out   <= 1'b0;
      disp0    <= '0;
      disp1    <= '0;
      disp2    <= '0;
    end else begin
      de_out <= s1_de;
      if (state == ST_VIDEO) begin
        tmds_ch0 <= enc0[9:0];
        tmds_ch1 <= enc1[9:0];
        tmds_ch2 <= enc2[9:0];
        disp0    <= enc0[14:10];
        disp1    <= enc1[14:10];
        disp2    <= enc2[14:10];
      end else begin
        tmds_ch0 <= is_guard ? SYM_GUARD_BR : ctl_sym(s1_c);
        tmds_ch1 <= is_pre ? SYM_CTL01 : (is_guard ? SYM_GUARD_G : SYM_CTL00);
        tmds_ch2 <= is_guard ? SYM_GUARD_BR : SYM_CTL00;
        disp0    <= '0;
        disp1    <= '0;
        disp2    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_tmds_framer.sv
// tb_hdmi_tmds_framer: randomized line traffic against a cycle-indexed
// reference model of the framer (latency, framing decision, preamble/guard
// windows, TMDS encoding with running disparity, reset behaviour).
// Follows the HDMI_GUARD_BAND_EN build option of the design.
module tb_hdmi_tmds_framer;

  localparam int P = 8;
  localparam int G = 2;
  localparam int D = P + G;
  localparam int L = D + 2;
  localparam int N = 4096;

  localparam logic [9:0] SYM00 = 10'b1101010100;
  localparam logic [9:0] SYM01 = 10'b0010101011;
  localparam logic [9:0] SYM10 = 10'b0101010100;
  localparam logic [9:0] SYM11 = 10'b1010101011;
  localparam logic [9:0] GB    = 10'b1011001100;
  localparam logic [9:0] GG    = 10'b0100110011;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] video_din = '0;
  logic        video_hsync = 1'b0;
  logic        video_vsync = 1'b0;
  logic        video_de = 1'b0;
  logic [9:0]  tmds_ch0, tmds_ch1, tmds_ch2;
  logic        de_out, blank_short;

  hdmi_tmds_framer #(.PREAMBLE_LEN(P), .GUARD_LEN(G)) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .video_din   (video_din),
    .video_hsync (video_hsync),
    .video_vsync (video_vsync),
    .video_de    (video_de),
    .tmds_ch0    (tmds_ch0),
    .tmds_ch1    (tmds_ch1),
    .tmds_ch2    (tmds_ch2),
    .de_out      (de_out),
    .blank_short (blank_short)
  );

  always #5 pclk = ~pclk;

  // Input history indexed by clock edge; last_rst[e] = latest edge <= e with reset low.
  logic [23:0] s_pix [N];
  logic        s_de  [N];
  logic [1:0]  s_c   [N];
  int          last_rst [N];
  int          disp [3];
  int          checks = 0;
  int          failures = 0;
  int          k = 0;
`ifdef HDMI_GUARD_BAND_EN
  int          frame_t = -1000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, k, got, want);
    end
  endtask

  // Sample j still present in the pipeline at edge e (no reset in between).
  function automatic logic alive(input int j, input int e);
    if (j < 0) return 1'b0;
    return last_rst[e] < j;
  endfunction

  function automatic logic de_seen(input int j, input int e);
    if (!alive(j, e)) return 1'b0;
    return s_de[j];
  endfunction

  function automatic logic [9:0] ctl(input logic [1:0] c);
    case (c)
      2'b00:   return SYM00;
      2'b01:   return SYM01;
      2'b10:   return SYM10;
      default: return SYM11;
    endcase
  endfunction

  // q_m bit i is the parity of d[0..i], complemented on odd bits in XNOR mode.
  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic [7:0] m;
    logic       xn;
    xn = ($countones(d) > 4) || (($countones(d) == 4) && !d[0]);
    q = '0;
    for (int i = 0; i < 8; i++) begin
      m = 8'((1 << (i + 1)) - 1);
      q[i] = (^(d & m)) ^ (xn & i[0]);
    end
    q[8] = !xn;
    return q;
  endfunction

  // Invert when disparity and data bias agree; disparity tracks ones-minus-zeros.
  function automatic logic [9:0] tmds_sym(input logic [8:0] qm, input int din, output int dout);
    int         bal;
    logic       inv;
    logic [9:0] s;
    bal = $countones(qm[7:0]) - 4;
    if (din == 0 || bal == 0) inv = !qm[8];
    else                      inv = ((din > 0) == (bal > 0));
    s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    dout = din + 2 * $countones(s) - 10;
    return s;
  endfunction

  task automatic check_edge();
    int         j;
    logic [1:0] c;
    logic       vid;
    logic       es;
    logic [9:0] e0, e1, e2;
    logic [23:0] px;
    es = 1'b0;
    if (last_rst[k] == k) begin
      disp = '{0, 0, 0};
      check("rst_lane0", tmds_ch0, SYM00);
      check("rst_lane1", tmds_ch1, SYM00);
      check("rst_lane2", tmds_ch2, SYM00);
      check("rst_de_out", de_out, 0);
      check("rst_blank_short", blank_short, 0);
      return;
    end
`ifdef HDMI_GUARD_BAND_EN
    if (de_seen(k - 1, k) && !de_seen(k - 2, k)) begin
      logic framed;
      framed = 1'b1;
      for (int i = k - D - 2; i <= k - 2; i++) if (de_seen(i, k)) framed = 1'b0;
      if (framed) frame_t = k - 1;
      else        es = 1'b1;
    end
`endif
    j = k - L;
    vid = de_seen(j, k);
    c = alive(j, k) ? s_c[j] : 2'b00;
    if (vid) begin
      px = s_pix[j];
      e0 = tmds_sym(min_trans(px[7:0]),   disp[0], disp[0]);
      e1 = tmds_sym(min_trans(px[15:8]),  disp[1], disp[1]);
      e2 = tmds_sym(min_trans(px[23:16]), disp[2], disp[2]);
    end else begin
      disp = '{0, 0, 0};
      e0 = ctl(c);
      e1 = SYM00;
      e2 = SYM00;
`ifdef HDMI_GUARD_BAND_EN
      if (alive(frame_t, k)) begin
        if (k >= frame_t + 2 && k <= frame_t + P + 1) begin
          e1 = SYM01;
        end else if (k >= frame_t + P + 2 && k <= frame_t + D + 1) begin
          e0 = GB;
          e1 = GG;
          e2 = GB;
        end
      end
`endif
    end
    check("lane0", tmds_ch0, e0);
    check("lane1", tmds_ch1, e1);
    check("lane2", tmds_ch2, e2);
    check("de_out", de_out, vid);
    check("blank_short", blank_short, es);
  endtask

  task automatic drive(input logic de, input logic [23:0] pix, input logic [1:0] c, input logic rst);
    @(negedge pclk);
    if (k >= N) begin
      $display("FAIL cycle_budget edge=%0d got=%0d want<%0d", k, k, N);
      $fatal(1, "stimulus exceeded history depth");
    end
    video_de = de;
    video_din = pix;
    {video_vsync, video_hsync} = c;
    s_de[k] = de;
    s_pix[k] = pix;
    s_c[k] = c;
    if (rst) begin
      if (reset_n) begin
        reset_n = 1'b0;
        #1;
        check("async_lane0", tmds_ch0, SYM00);
        check("async_lane1", tmds_ch1, SYM00);
        check("async_lane2", tmds_ch2, SYM00);
        check("async_de_out", de_out, 0);
        check("async_blank_short", blank_short, 0);
      end
      last_rst[k] = k;
    end else begin
      reset_n = 1'b1;
      last_rst[k] = (k == 0) ? -1 : last_rst[k-1];
    end
    @(posedge pclk);
    #1;
    check_edge();
    k++;
  endtask

  task automatic run_line(input int blank, input int len, input int mode, input int rst_at);
    for (int i = 0; i < blank; i++) drive(1'b0, 24'($urandom), 2'($urandom), 1'b0);
    for (int i = 0; i < len; i++)
      drive(1'b1, (mode == 1) ? 24'h000000 : 24'($urandom), 2'($urandom), (i == rst_at));
  endtask

  initial begin
    disp = '{0, 0, 0};
    for (int i = 0; i < 6; i++) drive(1'b0, 24'h0, 2'b01, 1'b1);
    for (int i = 0; i < 30; i++) drive(1'b0, 24'($urandom), 2'b01, 1'b0);
    run_line(100, 640, 0, -1);
    run_line(30, 50, 1, -1);
    run_line(5, 20, 0, -1);
    run_line(40, 1, 0, -1);
    run_line(3, 10, 0, -1);
    run_line(25, 60, 0, 30);
    run_line(20, 40, 0, -1);
    for (int n = 0; n < 12; n++)
      run_line($urandom_range(1, 30), $urandom_range(1, 40), $urandom_range(0, 1), -1);
    run_line(40, 0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
